mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Arbitrates the single shared memory port between the two snooping caches (cache0, cache1).
//  Grants one cache at a time, round-robin, and holds the grant for one complete RD or WT transaction.
//  Latches the granted request onto the memory port and routes the memory completion pulse back
//  to the granted cache only. A timeout guard releases the bus if memory never answers.
// PARAMETERS
//  ADDRWIDTH     16  address width, same as cache addr ports
//  WORDWIDTH     32  data word width
//  IOSTATEWIDTH  2   rw code width; IDEL=2'd0, RD=2'd1, WT=2'd2 per def.v; 2'd3 is illegal
//  TIMEOUT       64  max BUSY cycles before forced release, 1..255
// PORTS
//  clk               in   1             clock, all state updates on posedge
//  reset             in   1             synchronous, active-low reset
//  rwFromCache0      in   IOSTATEWIDTH  cache0 request: IDEL/RD/WT, held until done
//  addrFromCache0    in   ADDRWIDTH     cache0 request address
//  dataFromCache0    in   WORDWIDTH     cache0 write data
//  rwFromCache1      in   IOSTATEWIDTH  cache1 request
//  addrFromCache1    in   ADDRWIDTH     cache1 request address
//  dataFromCache1    in   WORDWIDTH     cache1 write data
//  readEnToCache0    out  1             read-complete pulse to cache0
//  writeDoneToCache0 out  1             write-complete pulse to cache0
//  readEnToCache1    out  1             read-complete pulse to cache1
//  writeDoneToCache1 out  1             write-complete pulse to cache1
//  dataToCaches      out  WORDWIDTH     dataFromMem, passed through to both caches
//  addrToCaches      out  ADDRWIDTH     addrFromMem, passed through to both caches
//  rwToMem           out  IOSTATEWIDTH  registered memory command
//  addrToMem         out  ADDRWIDTH     registered memory address
//  dataToMem         out  WORDWIDTH     registered memory write data
//  readEnFromMem     in   1             memory read complete, 1-cycle pulse
//  writeDoneFromMem  in   1             memory write complete, 1-cycle pulse
//  dataFromMem       in   WORDWIDTH     memory read data, valid with readEnFromMem
//  addrFromMem       in   ADDRWIDTH     memory read address, valid with readEnFromMem
//  grant             out  2             one-hot current owner: bit0 = cache0, bit1 = cache1
//  timeoutErr        out  1             1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE, grant=0, rwToMem=IDEL, addrToMem=0, dataToMem=0, timeoutErr=0, cnt=0.
//   - lastGrant=1, so cache0 wins the first tie.
//   - All completion pulses to the caches are 0 while reset is low, including reset mid-BUSY;
//     the in-flight transaction is dropped.
//  State IDLE: reqN = (rwFromCacheN != IDEL).
//   - One requester -> grant it.
//   - Both requesting -> grant the one that is not lastGrant.
//   - On grant, at the next posedge: state=BUSY, grant set, lastGrant=winner, cnt=0,
//     and rw/addr/data of the winner are latched into rwToMem/addrToMem/dataToMem.
//   - Latency: request at edge N is visible on the memory port after edge N+1.
//  State BUSY: the latched request stays stable; caches may change their inputs freely.
//   - done = (latched RD & readEnFromMem) | (latched WT & writeDoneFromMem).
//   - done -> the matching pulse goes to the granted cache in the same cycle (combinational);
//     the next posedge sets state=IDLE, grant=0, rwToMem=IDEL.
//   - A completion of the wrong type (e.g. readEn during WT) is ignored and not forwarded.
//   - Granted cache drops rw to IDEL before done (abort) -> release as on done; nothing forwarded.
//   - cnt increments every BUSY cycle without done.
//   - cnt reaching TIMEOUT-1 with no done -> timeoutErr=1 for one cycle, release to IDLE.
//   - done in that same cycle wins: pulse forwarded, no timeoutErr.
//  Turnaround: IDLE lasts >=1 cycle, so rwToMem is IDEL for >=1 cycle between transactions.
//   - Round-robin then lets the other cache in before a back-to-back re-request
//     (a write-back followed by a fill may be split).
//  Completions arriving in IDLE are ignored.
//  Illegal rw code 2'd3 is never granted and is treated as IDEL.
//  dataToCaches and addrToCaches are pure pass-through at all times.
// TESTING
//  1 Cache0 RD addr 0x0010; memory returns readEn with data 0xDEADBEEF 3 cycles later
//    -> grant=01; readEnToCache0=1 with dataToCaches=0xDEADBEEF; readEnToCache1=0;
//    rwToMem=IDEL next cycle.
//  2 Both request in the same cycle after reset -> cache0 first; after its done and 1 idle cycle,
//    grant=10; cache1 then re-request while cache0 requests -> cache0 granted.
//  3 Cache1 WT addr 0x0020 data 0x12345678; cache1 changes addr mid-BUSY
//    -> addrToMem stays 0x0020; writeDoneToCache1 pulses once.
//  4 Granted RD, memory silent for 64 cycles -> timeoutErr pulse on cycle 64, grant=00,
//    pending cache1 granted 2 cycles later.
//  5 writeDoneFromMem during a latched RD -> no pulse to either cache; BUSY continues;
//    the later readEn completes normally.
//  6 reset low mid-BUSY -> next cycle all outputs at reset values; a readEn during reset
//    is not forwarded.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single memory port between the two snooping caches. One cache
// at a time owns the port, round-robin, for exactly one RD or WT
// transaction. The winning request is latched onto the memory port, and the
// memory completion pulse is routed back to the owner only. If memory never
// answers, a timeout guard releases the bus and flags timeoutErr.
//
// Ports
//   clk, reset                       clock, synchronous active-low reset
//   rwFromCacheN/addr../data..       request from cache N (IDEL/RD/WT)
//   readEnToCacheN/writeDoneToCacheN completion pulses to cache N
//   dataToCaches/addrToCaches        memory read data/address pass-through
//   rwToMem/addrToMem/dataToMem      registered memory command
//   readEnFromMem/writeDoneFromMem   memory completion pulses
//   dataFromMem/addrFromMem          memory read data/address
//   grant                            one-hot owner (bit0 cache0, bit1 cache1)
//   timeoutErr                       one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDRWIDTH    = 16,
    parameter int WORDWIDTH    = 32,
    parameter int IOSTATEWIDTH = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rwFromCache0,
    input  logic [ADDRWIDTH-1:0]    addrFromCache0,
    input  logic [WORDWIDTH-1:0]    dataFromCache0,
    input  logic [IOSTATEWIDTH-1:0] rwFromCache1,
    input  logic [ADDRWIDTH-1:0]    addrFromCache1,
    input  logic [WORDWIDTH-1:0]    dataFromCache1,
    output logic                    readEnToCache0,
    output logic                    writeDoneToCache0,
    output logic                    readEnToCache1,
    output logic                    writeDoneToCache1,
    output logic [WORDWIDTH-1:0]    dataToCaches,
    output logic [ADDRWIDTH-1:0]    addrToCaches,
    output logic [IOSTATEWIDTH-1:0] rwToMem,
    output logic [ADDRWIDTH-1:0]    addrToMem,
    output logic [WORDWIDTH-1:0]    dataToMem,
    input  logic                    readEnFromMem,
    input  logic                    writeDoneFromMem,
    input  logic [WORDWIDTH-1:0]    dataFromMem,
    input  logic [ADDRWIDTH-1:0]    addrFromMem,
    output logic [1:0]              grant,
    output logic                    timeoutErr
);

    localparam logic [IOSTATEWIDTH-1:0] IDEL = IOSTATEWIDTH'(0);
    localparam logic [IOSTATEWIDTH-1:0] RD   = IOSTATEWIDTH'(1);
    localparam logic [IOSTATEWIDTH-1:0] WT   = IOSTATEWIDTH'(2);
    localparam logic [7:0]              LASTCOUNT = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} arbState;

    arbState state;
    logic [7:0] cnt;
    logic lastGrant;

    logic req0, req1, pickCache1;
    logic busy, latchedRd, latchedWt, done;
    logic [IOSTATEWIDTH-1:0] ownerRw;
    logic ownerReq, abort, expired, forward;

    // Request decode and arbitration. The illegal code 2'd3 never counts as
    // a request. Cache1 wins when it is alone, or when both ask and cache0
    // was the previous owner (lastGrant holds the index of the last winner).
    always_comb begin
        req0       = (rwFromCache0 == RD) || (rwFromCache0 == WT);
        req1       = (rwFromCache1 == RD) || (rwFromCache1 == WT);
        pickCache1 = req1 && (!req0 || !lastGrant);
    end

    // Transaction end conditions while BUSY. Only a completion matching the
    // latched command counts as done. An owner that withdraws its request
    // aborts the transaction, and the timeout only fires when neither of the
    // other two ends happened in the same cycle, so a late done still wins.
    always_comb begin
        busy      = (state == BUSY);
        latchedRd = (rwToMem == RD);
        latchedWt = (rwToMem == WT);
        done      = busy && ((latchedRd && readEnFromMem) || (latchedWt && writeDoneFromMem));
        ownerRw   = grant[1] ? rwFromCache1 : rwFromCache0;
        ownerReq  = (ownerRw == RD) || (ownerRw == WT);
        abort     = busy && !done && !ownerReq;
        expired   = busy && !done && !abort && (cnt == LASTCOUNT);
        forward   = done && reset;
    end

    // Completion pulses go to the owner in the same cycle memory answers;
    // they are held off while reset is low so an in-flight transaction is
    // silently dropped. Read data and address are shared pass-throughs.
    assign readEnToCache0    = forward && grant[0] && latchedRd;
    assign writeDoneToCache0 = forward && grant[0] && latchedWt;
    assign readEnToCache1    = forward && grant[1] && latchedRd;
    assign writeDoneToCache1 = forward && grant[1] && latchedWt;
    assign dataToCaches      = dataFromMem;
    assign addrToCaches      = addrFromMem;

    // Arbiter state machine with registered memory port. IDLE always lasts
    // at least one cycle, which gives rwToMem an IDEL gap between
    // transactions and lets round-robin hand the bus to the other cache.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 2'b00;
            rwToMem    <= IDEL;
            addrToMem  <= '0;
            dataToMem  <= '0;
            timeoutErr <= 1'b0;
            cnt        <= 8'd0;
            lastGrant  <= 1'b1;
        end else begin
            timeoutErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state <= BUSY;
                        cnt   <= 8'd0;
                        if (pickCache1) begin
                            grant     <= 2'b10;
                            lastGrant <= 1'b1;
                            rwToMem   <= rwFromCache1;
                            addrToMem <= addrFromCache1;
                            dataToMem <= dataFromCache1;
                        end else begin
                            grant     <= 2'b01;
                            lastGrant <= 1'b0;
                            rwToMem   <= rwFromCache0;
                            addrToMem <= addrFromCache0;
                            dataToMem <= dataFromCache0;
                        end
                    end
                end
                BUSY: begin
                    if (done || abort || expired) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        rwToMem    <= IDEL;
                        timeoutErr <= expired;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
